pong_score: RTL and testbench
=============================

# pong_score

Match-state and score keeper for the pong game. It sits directly upstream of the two per-player 7-segment decoders and drives their 4-bit digit inputs. It turns one-cycle point pulses from the ball/collision logic into per-player scores, times the serve delay and detects the winner. At game over it alternates the digit codes between the win/loss glyphs and the final score.

## Interface

**Parameters**
- `WIN_SCORE`, default 7: points needed to win. Legal range 1..10; a score of 10 displays as code 10.
- `SERVE_CYCLES`, default 50_000_000: delay from a point (or start) to the next serve. Minimum 1.
- `BLINK_CYCLES`, default 25_000_000: duration of each half of the game-over display alternation. Minimum 1.

**Ports**
- `clk` input 1: system clock; every register is clocked on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: start/restart button level, already synchronised. Only its rising edge acts.
- `point_l` input 1: one-cycle pulse, left player scored.
- `point_r` input 1: one-cycle pulse, right player scored.
- `hex_l` output 4: digit code for the left display.
- `hex_r` output 4: digit code for the right display.
- `serve` output 1: one-cycle pulse telling ball logic to launch.
- `playing` output 1: high only in PLAY; gates paddle and ball motion.
- `game_over` output 1: high in OVER.
- `winner` output 1: 0 = left, 1 = right. Valid while `game_over` is high; holds its last value otherwise.

## Operation

- Every output is registered. Reset values: `hex_l` = `hex_r` = 0, `serve` = 0, `playing` = 0, `game_over` = 0, `winner` = 0. After reset the state is IDLE, both scores are 0 and all timers are 0.
- The `start` rising edge is detected internally from a registered copy of `start`; that copy resets to 0.
- **IDLE**: scores are held at 0 and points are ignored. A start edge clears the timer and moves to SERVE.
- **SERVE**: the timer counts up to SERVE_CYCLES-1. On the terminal count, `serve` pulses for exactly one cycle, the timer clears and the state moves to PLAY. Points are ignored.
- **PLAY**: handles point pulses as follows.
  - `point_l` alone: the left score increments.
  - `point_r` alone: the right score increments.
  - Both in the same cycle: both are ignored and the state is unchanged.
  - After an increment, if the new score equals WIN_SCORE: go to OVER, set `winner`, clear the blink timer and set the blink phase to 0.
  - Otherwise: go to SERVE with the timer cleared.
- **OVER**: the blink timer counts to BLINK_CYCLES-1, then wraps and toggles the phase.
  - Phase 0: the winner's digit shows 11 and the loser's digit shows 12.
  - Phase 1: both digits show their final scores.
  - Points are ignored.
  - A start edge clears both scores, clears `winner` and `game_over`, and goes to SERVE.
- **Start edge in SERVE or PLAY**: restarts the match. Scores clear and the state goes to SERVE with the timer cleared. A restart takes priority over a point pulse in the same cycle.
- Outside OVER, `hex_l` and `hex_r` equal the current scores. Scores are 4 bits wide and never exceed WIN_SCORE, so they never wrap.
- A reset asserted mid-operation forces the reset values immediately and asynchronously. This includes mid-serve: no `serve` pulse is emitted.

## Timing

- A point pulse in cycle n updates `hex_*` in cycle n+1; the state becomes SERVE or OVER in n+1.
- From SERVE entry in cycle m, `serve` is high in cycle m+SERVE_CYCLES and `playing` rises in that same cycle.
- A start edge sampled in cycle n means SERVE is entered in n+1; `start` must be low for at least one sampled cycle between edges.
- A winning point in cycle n gives `game_over` = 1 and the win/loss codes in n+1. The first toggle to scores occurs BLINK_CYCLES cycles later.
- The single timer counter is shared between SERVE and OVER. Its width is $clog2 of the larger of SERVE_CYCLES and BLINK_CYCLES.

## Structure

- The shared game package/header holds the state encoding (IDLE, SERVE, PLAY, OVER) and the glyph constants `CODE_WIN` = 4'd11 and `CODE_LOSS` = 4'd12. The decoders use the same constants.
- One sub-module, `pong_timer`: a synchronous-clear up-counter with a terminal-count output and a run-time limit input. It is used for both the serve delay and the blink period.
- Output muxing is done in the top block; the counter sits in `pong_timer`.

## Test plan

Bench parameters for all scenarios: WIN_SCORE=3, SERVE_CYCLES=4, BLINK_CYCLES=8.

- **Reset and idle**: assert `rst`, release, pulse `point_l` -> `hex_l`=`hex_r`=0, `playing`=0; pulse `start` -> `serve` high exactly 4 cycles after SERVE entry, then `playing`=1.
- **Scoring**: in PLAY, pulse `point_r` -> `hex_r`=1 next cycle and `playing`=0. After 4 cycles `serve` pulses. A `point_l` during SERVE leaves `hex_l`=0.
- **Simultaneous points**: in PLAY, pulse `point_l` and `point_r` in the same cycle -> both scores unchanged and the state stays PLAY.
- **Win and blink**: the left player reaches 3 -> `game_over`=1, `winner`=0, `hex_l`=11, `hex_r`=12 for 8 cycles, then `hex_l`=3 and `hex_r`=the right score for 8 cycles, repeating.
- **Restart**: a start edge in OVER and again mid-PLAY at 2:1 -> scores 0:0, `game_over`=0, `serve` pulse 4 cycles after SERVE entry.
- **Asynchronous reset**: assert `rst` mid-SERVE between clock edges -> outputs reach their reset values before the next edge and no `serve` pulse appears.

Source files
------------

// File: rtl/pong_score_pkg.sv
// Shared pong game definitions: match states, glyph codes and
// the digit selection helper used by the score keeper.
package pong_score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [3:0] CODE_WIN  = 4'd11;
  localparam logic [3:0] CODE_LOSS = 4'd12;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase 0 of game over shows glyphs, otherwise the score itself.
  function automatic logic [3:0] digit(
    input state_e     st,
    input logic       ph,
    input logic       is_win,
    input logic [3:0] sc
  );
    if (st == ST_OVER && !ph)
      return is_win ? CODE_WIN : CODE_LOSS;
    return sc;
  endfunction

endpackage

// File: rtl/pong_timer.sv
// Up-counter with synchronous clear and a run-time terminal count,
// shared by the serve delay and the game-over blink period.
module pong_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == i_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr || o_tc)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/pong_score.sv
// Pong match state and score keeper: serve timing, scoring,
// winner detection and the game-over digit alternation.
module pong_score
  import pong_score_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       point_l,
  input  logic       point_r,
  output logic [3:0] hex_l,
  output logic [3:0] hex_r,
  output logic       serve,
  output logic       playing,
  output logic       game_over,
  output logic       winner
);

  localparam int MAXC = max2(SERVE_CYCLES, BLINK_CYCLES);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] SERVE_LIM = TW'(SERVE_CYCLES - 1);
  localparam logic [TW-1:0] BLINK_LIM = TW'(BLINK_CYCLES - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  state_e     r_state;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;
  logic       r_phase;
  logic       r_start_q;

  state_e     w_state_nxt;
  logic [3:0] w_sl_nxt;
  logic [3:0] w_sr_nxt;
  logic       w_phase_nxt;
  logic       w_win_nxt;
  logic       w_serve_nxt;
  logic       w_clr;
  logic       w_en;
  logic       w_tc;
  logic       w_edge;
  logic [TW-1:0] w_limit;

  assign w_edge  = start & ~r_start_q;
  assign w_en    = (r_state == ST_SERVE) || (r_state == ST_OVER);
  assign w_limit = (r_state == ST_SERVE) ? SERVE_LIM : BLINK_LIM;

  pong_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sl_nxt    = r_score_l;
    w_sr_nxt    = r_score_r;
    w_phase_nxt = r_phase;
    w_win_nxt   = winner;
    w_serve_nxt = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt = ST_SERVE;
          w_clr       = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_edge) begin
          w_sl_nxt = 4'd0;
          w_sr_nxt = 4'd0;
          w_clr    = 1'b1;
        end else if (w_tc) begin
          w_serve_nxt = 1'b1;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_edge) begin
          w_sl_nxt    = 4'd0;
          w_sr_nxt    = 4'd0;
          w_state_nxt = ST_SERVE;
          w_clr       = 1'b1;
        end else if (point_l ^ point_r) begin
          if (point_l) w_sl_nxt = r_score_l + 4'd1;
          else         w_sr_nxt = r_score_r + 4'd1;
          w_clr = 1'b1;
          if (w_sl_nxt == WIN || w_sr_nxt == WIN) begin
            w_state_nxt = ST_OVER;
            w_win_nxt   = point_r;
            w_phase_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (w_edge) begin
          w_sl_nxt    = 4'd0;
          w_sr_nxt    = 4'd0;
          w_win_nxt   = 1'b0;
          w_state_nxt = ST_SERVE;
          w_clr       = 1'b1;
        end else if (w_tc) begin
          w_phase_nxt = ~r_phase;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
      r_phase   <= 1'b0;
      r_start_q <= 1'b0;
      hex_l     <= 4'd0;
      hex_r     <= 4'd0;
      serve     <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_score_l <= w_sl_nxt;
      r_score_r <= w_sr_nxt;
      r_phase   <= w_phase_nxt;
      r_start_q <= start;
      serve     <= w_serve_nxt;
      playing   <= (w_state_nxt == ST_PLAY);
      game_over <= (w_state_nxt == ST_OVER);
      winner    <= w_win_nxt;
      hex_l     <= digit(w_state_nxt, w_phase_nxt, ~w_win_nxt, w_sl_nxt);
      hex_r     <= digit(w_state_nxt, w_phase_nxt, w_win_nxt, w_sr_nxt);
    end
  end

endmodule

// File: tb/tb_pong_score.sv
// Self-checking bench for pong_score: directed match scenarios
// followed by random play against a cycle-index reference model.
module tb_pong_score;

  localparam int W = 3;
  localparam int S = 4;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       point_l;
  logic       point_r;
  logic [3:0] hex_l;
  logic [3:0] hex_r;
  logic       serve;
  logic       playing;
  logic       game_over;
  logic       winner;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: absolute cycle numbers instead of a state register
  int k;
  int m_active;
  int wait_at;
  int over_at;
  int ml;
  int mr;
  bit m_win;
  bit m_prev;
  bit m_serve;

  pong_score #(
    .WIN_SCORE    (W),
    .SERVE_CYCLES (S),
    .BLINK_CYCLES (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .point_l   (point_l),
    .point_r   (point_r),
    .hex_l     (hex_l),
    .hex_r     (hex_r),
    .serve     (serve),
    .playing   (playing),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d",
             tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    wait_at  = -1;
    over_at  = -1;
    ml       = 0;
    mr       = 0;
    m_win    = 0;
    m_prev   = 0;
    m_serve  = 0;
  endtask

  task automatic check_all();
    bit e_over;
    bit e_play;
    int ph;
    int e_hl;
    int e_hr;
    e_over = (over_at >= 0);
    e_play = (m_active != 0) && !e_over && (wait_at < 0);
    ph     = e_over ? ((k - over_at) / B) % 2 : 1;
    e_hl   = ml;
    e_hr   = mr;
    if (e_over && ph == 0) begin
      e_hl = m_win ? 12 : 11;
      e_hr = m_win ? 11 : 12;
    end
    chk("hex_l", hex_l, 4'(e_hl));
    chk("hex_r", hex_r, 4'(e_hr));
    chk("serve", {3'b0, serve}, {3'b0, m_serve});
    chk("playing", {3'b0, playing}, {3'b0, e_play});
    chk("game_over", {3'b0, game_over}, {3'b0, e_over});
    chk("winner", {3'b0, winner}, {3'b0, m_win});
  endtask

  // Advances the model across the next rising edge
  task automatic model_update(input bit s, input bit pl, input bit pr);
    bit edg;
    k++;
    edg     = s && !m_prev;
    m_prev  = s;
    m_serve = 0;
    if (m_active == 0) begin
      if (edg) begin
        m_active = 1;
        wait_at  = k + S;
      end
    end else if (over_at >= 0) begin
      if (edg) begin
        ml = 0; mr = 0; m_win = 0;
        over_at = -1;
        wait_at = k + S;
      end
    end else if (wait_at >= 0) begin
      if (edg) begin
        ml = 0; mr = 0;
        wait_at = k + S;
      end else if (k == wait_at) begin
        m_serve = 1;
        wait_at = -1;
      end
    end else begin
      if (edg) begin
        ml = 0; mr = 0;
        wait_at = k + S;
      end else if (pl != pr) begin
        if (pl) ml++;
        else    mr++;
        if (ml == W || mr == W) begin
          over_at = k;
          m_win   = pr;
        end else begin
          wait_at = k + S;
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit pl, input bit pr);
    @(negedge clk);
    check_all();
    start   = s;
    point_l = pl;
    point_r = pr;
    model_update(s, pl, pr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    check_all();
    rst     = 1'b0;
    start   = 1'b0;
    point_l = 1'b0;
    point_r = 1'b0;
    model_update(0, 0, 0);
  endtask

  initial begin
    k       = 0;
    rst     = 1'b1;
    start   = 1'b0;
    point_l = 1'b0;
    point_r = 1'b0;
    model_reset();
    #12;
    check_all();
    release_rst();

    // Points ignored in idle, then first serve
    step(0, 1, 0);
    step(1, 0, 0);
    run(6);

    // Right scores; a left point during serve is ignored
    step(0, 0, 1);
    step(0, 1, 0);
    run(6);

    // Simultaneous points leave the score unchanged
    step(0, 1, 1);
    run(2);

    // Left wins 3:1 and the display alternates
    step(0, 1, 0);
    run(6);
    step(0, 1, 0);
    run(6);
    step(0, 1, 0);
    run(3 * B + 3);

    // Restart from game over, then reach 2:1
    step(1, 0, 0);
    run(6);
    step(0, 1, 0);
    run(6);
    step(0, 1, 0);
    run(6);
    step(0, 0, 1);
    run(6);

    // Restart mid-play takes priority over a point
    step(1, 0, 1);
    run(6);

    // Asynchronous reset between edges while serving
    step(0, 1, 0);
    run(2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      check_all();
    end
    release_rst();
    run(2);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 50) == 0, ($urandom % 6) == 0,
           ($urandom % 6) == 0);
    end
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
